// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : 5-stage pipeline hazard unit (freeze, flush, load-use
//                    stall, operand forwarding, memory-wait watchdog)
// Revision 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic [4:0]  ID_EX_rs,
  input  logic [4:0]  ID_EX_rt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_RegWrite,
  input  logic [4:0]  MEM_WB_rd,
  input  logic        MEM_WB_RegWrite,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_hold,
  output logic        ID_EX_bubble,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic        wait_error
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [7:0]  c_wait_limit = 8'(WAIT_LIMIT);
  localparam logic [15:0] c_cnt_max    = 16'hFFFF;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  logic w_freeze;
  logic w_load_use;
  logic w_do_flush;
  logic w_do_stall;

  assign w_freeze   = mem_busy || (r_state == ST_ERROR);
  assign w_load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
  assign w_do_flush = !w_freeze && branch_taken;
  assign w_do_stall = !w_freeze && !branch_taken && w_load_use;

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_hold   = 1'b0;
    ID_EX_bubble = 1'b0;
    if (w_freeze) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_hold  = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (w_load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  // EX/MEM result is newer than MEM/WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (EX_MEM_RegWrite && (EX_MEM_rd != 5'd0) && (EX_MEM_rd == src))
      return 2'b10;
    else if (MEM_WB_RegWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardA = fwd_sel(ID_EX_rs);
  assign ForwardB = fwd_sel(ID_EX_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_busy) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == c_wait_limit) begin
            r_state <= ST_ERROR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
      if (w_do_stall && (r_stall_count != c_cnt_max))
        r_stall_count <= r_stall_count + 16'd1;
      if (w_do_flush && (r_flush_count != c_cnt_max))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
  assign wait_error  = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- IF_ID_rs, IF_ID_rt  in  5 each  source registers of the instruction in decode.
- ID_EX_rs, ID_EX_rt  in  5 each  source registers of the instruction in execute.
- ID_EX_MemRead  in  1  execute-stage instruction is a load.
- EX_MEM_rd, EX_MEM_RegWrite  in  5/1  memory-stage destination and write enable.
- MEM_WB_rd, MEM_WB_RegWrite  in  5/1  writeback-stage destination and write enable.
- branch_taken  in  1  resolved taken branch this cycle.
- mem_busy  in  1  data memory not ready; pipeline must freeze.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register load enable.
- IF_ID_flush  out  1  IF/ID register clears to NOP.
- ID_EX_hold  out  1  ID/EX register retains contents.
- ID_EX_bubble  out  1  ID/EX control fields load zero.
- ForwardA, ForwardB  out  2 each  ALU operand mux selects.
- stall_count, flush_count  out  16 each  performance counters.
- wait_error  out  1  sticky memory-wait timeout flag.
REQ-002 The clock port SHALL be clk and reset SHALL be reset, synchronous and active-high.
REQ-003 The block SHALL have one parameter: WAIT_LIMIT, default 255, maximum consecutive mem_busy cycles before timeout (8-bit range).

Function
REQ-004 FSM states SHALL be RUN, MEM_WAIT, ERROR; 8-bit wait_cnt accompanies MEM_WAIT.
REQ-005 freeze = mem_busy OR state==ERROR (combinational).
REQ-006 freeze SHALL drive PC_write=0, IF_ID_write=0, ID_EX_hold=1, IF_ID_flush=0, ID_EX_bubble=0.
REQ-007 load_use = ID_EX_MemRead AND ID_EX_rt!=0 AND (ID_EX_rt==IF_ID_rs OR ID_EX_rt==IF_ID_rt).
REQ-008 Priority SHALL be freeze > branch_taken > load_use > normal.
REQ-009 branch (not frozen): IF_ID_flush=1, ID_EX_bubble=1, PC_write=1, IF_ID_write=1, ID_EX_hold=0, same cycle.
REQ-010 load_use (not frozen, no branch): PC_write=0, IF_ID_write=0, ID_EX_bubble=1, ID_EX_hold=0; single-cycle stall.
REQ-011 Normal: PC_write=1, IF_ID_write=1, all others 0.
REQ-012 ForwardA SHALL be 2'b10 if EX_MEM_RegWrite AND EX_MEM_rd!=0 AND EX_MEM_rd==ID_EX_rs; else 2'b01 if MEM_WB_RegWrite AND MEM_WB_rd!=0 AND MEM_WB_rd==ID_EX_rs; else 2'b00; ForwardB identical using ID_EX_rt; computed in all states.
REQ-013 RUN: mem_busy=1 -> MEM_WAIT, wait_cnt<=1; else stay.
REQ-014 MEM_WAIT: mem_busy=0 -> RUN, wait_cnt<=0; else wait_cnt==WAIT_LIMIT -> ERROR; else wait_cnt<=wait_cnt+1.
REQ-015 ERROR SHALL persist until reset; wait_error = (state==ERROR).
REQ-016 stall_count SHALL increment by 1 each cycle REQ-010 applies; flush_count each cycle REQ-009 applies; both saturate at 16'hFFFF.
REQ-017 Neither counter SHALL increment in a frozen cycle.

Reset
REQ-018 reset=1 at posedge SHALL set state=RUN, wait_cnt=0, stall_count=0, flush_count=0, wait_error=0, overriding any in-progress MEM_WAIT or ERROR.
REQ-019 Combinational outputs SHALL follow REQ-005..012 from reset state and current inputs; with mem_busy=0 during reset the pipeline runs.

Verification
REQ-020 Load-use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 one cycle; stall_count 0->1.
REQ-021 Branch+load-use same cycle -> IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; flush_count+1, stall_count unchanged.
REQ-022 Forwarding: EX_MEM_rd=MEM_WB_rd=ID_EX_rs=3, both RegWrite=1 -> ForwardA=10; EX_MEM_rd=0, MEM_WB_rd=ID_EX_rt=0 -> ForwardB=00.
REQ-023 mem_busy high 4 cycles then low -> freeze exactly 4 cycles, state back to RUN, wait_error=0, counters unchanged.
REQ-024 mem_busy held 300 cycles (WAIT_LIMIT=255) -> wait_error=1 after 256th busy cycle, stays 1 after mem_busy drops; reset -> wait_error=0, PC_write=1.
REQ-025 stall_count preloaded to 16'hFFFF via 65535 stalls, further load-use -> stays 16'hFFFF.
